// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between fetch (read-only) and the memory stage (load/store).
// Ports:
//   i_clk, i_reset                    clock and synchronous active-high reset
//   i_if_req/i_if_addr                fetch read request and address
//   o_if_gnt/o_if_rvalid/o_if_rdata   fetch grant, response valid (cycle after grant), read data
//   i_mem_req/i_mem_we/i_mem_addr     memory-stage request, write flag, address
//   i_mem_wdata/i_mem_wmask           memory-stage write data and byte enables
//   o_mem_gnt/o_mem_rvalid/o_mem_rdata memory grant, read response valid, read data
//   o_ram_addr/o_ram_we/o_ram_wdata/o_ram_wmask  RAM command, follows the granted requester
//   i_ram_rdata                       RAM read data, one cycle after the address is sampled
module ram_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_rvalid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_mem_req,
    input  logic                i_mem_we,
    input  logic [ADDR_W-1:0]   i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    input  logic [DATA_W/8-1:0] i_mem_wmask,
    output logic                o_mem_gnt,
    output logic                o_mem_rvalid,
    output logic [DATA_W-1:0]   o_mem_rdata,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic                o_ram_we,
    output logic [DATA_W-1:0]   o_ram_wdata,
    output logic [DATA_W/8-1:0] o_ram_wmask,
    input  logic [DATA_W-1:0]   i_ram_rdata
);
    localparam int SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    typedef enum logic [1:0] {RESP_NONE, RESP_IF, RESP_MEM} resp_t;
    resp_t         r_owner, w_owner_next;
    logic [SW-1:0] r_starve, w_starve_next;
    logic          w_force;
    logic          w_sat;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner  <= RESP_NONE;
            r_starve <= '0;
        end else begin
            r_owner  <= w_owner_next;
            r_starve <= w_starve_next;
        end
    end
    always_comb begin
        w_sat         = r_starve == SW'(MAX_STARVE);
        w_force       = (MAX_STARVE > 0) && w_sat;
        o_if_gnt      = !i_reset && i_if_req && (!i_mem_req || w_force);
        o_mem_gnt     = !i_reset && i_mem_req && !o_if_gnt;
        w_owner_next  = o_if_gnt ? RESP_IF : (o_mem_gnt && !i_mem_we) ? RESP_MEM : RESP_NONE;
        w_starve_next = (!i_if_req || o_if_gnt) ? '0 : w_sat ? r_starve : r_starve + 1'b1;
        o_ram_addr    = o_mem_gnt ? i_mem_addr : i_if_addr;
        o_ram_we      = o_mem_gnt && i_mem_we;
        o_ram_wdata   = i_mem_wdata;
        o_ram_wmask   = o_ram_we ? i_mem_wmask : '0;
    end
    // Gating with reset drops a response whose grant happened just before reset rose.
    assign o_if_rvalid  = (r_owner == RESP_IF) && !i_reset;
    assign o_mem_rvalid = (r_owner == RESP_MEM) && !i_reset;
    assign o_if_rdata   = i_ram_rdata;
    assign o_mem_rdata  = i_ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter with a small RAM model.
module tb_ram_port_arbiter;
    localparam int MS = 4;
    logic        clk = 0;
    logic        rst, ir, mr, mw;
    logic [15:0] ia, ma;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        ig, irv, mg, mrv, rwe;
    logic [31:0] ird, mrd, rwd, rq;
    logic [15:0] ra;
    logic [3:0]  rwm;
    logic [31:0] tb_mem [0:255];
    int          tests = 0;
    int          fails = 0;
    always #5 clk = ~clk;
    ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_STARVE(MS)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(ir), .i_if_addr(ia), .o_if_gnt(ig), .o_if_rvalid(irv), .o_if_rdata(ird),
        .i_mem_req(mr), .i_mem_we(mw), .i_mem_addr(ma), .i_mem_wdata(wd), .i_mem_wmask(wm),
        .o_mem_gnt(mg), .o_mem_rvalid(mrv), .o_mem_rdata(mrd),
        .o_ram_addr(ra), .o_ram_we(rwe), .o_ram_wdata(rwd), .o_ram_wmask(rwm),
        .i_ram_rdata(rq)
    );
    always @(posedge clk) begin
        rq <= tb_mem[ra[9:2]];
        if (rwe)
            for (int b = 0; b < 4; b++)
                if (rwm[b]) tb_mem[ra[9:2]][8*b +: 8] <= rwd[8*b +: 8];
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    typedef struct {
        logic        rst, ir, mr, mw;
        logic [15:0] ia, ma;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        eig, emg, ewe;
        logic [15:0] ea;
        logic        eirv, emrv;
        logic [31:0] ed;
    } vec_t;
    vec_t tbl[$];
    function automatic vec_t mk(logic r, logic i_r, logic m_r, logic m_w, logic [15:0] i_a, logic [15:0] m_a,
                                logic [31:0] w_d, logic [3:0] w_m, logic e_ig, logic e_mg, logic e_we,
                                logic [15:0] e_a, logic e_irv, logic e_mrv, logic [31:0] e_d);
        vec_t v;
        v.rst = r; v.ir = i_r; v.mr = m_r; v.mw = m_w; v.ia = i_a; v.ma = m_a; v.wd = w_d; v.wm = w_m;
        v.eig = e_ig; v.emg = e_mg; v.ewe = e_we; v.ea = e_a; v.eirv = e_irv; v.emrv = e_mrv; v.ed = e_d;
        return v;
    endfunction
    task automatic drive(input logic r, input logic i_r, input logic m_r, input logic m_w,
                         input logic [15:0] i_a, input logic [15:0] m_a, input logic [31:0] w_d, input logic [3:0] w_m);
        rst = r; ir = i_r; mr = m_r; mw = m_w; ia = i_a; ma = m_a; wd = w_d; wm = w_m;
        #1;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    int          denied, owner, c;
    logic [31:0] pdata;
    logic        eig, emg;
    initial begin
        for (int k = 0; k < 256; k++) tb_mem[k] = 32'hA5000000 | k;
        tb_mem[4]  = 32'hDEADBEEF;
        tb_mem[8]  = 32'h0BAD0020;
        tb_mem[64] = 32'hCAFE0100;
        tbl.push_back(mk(1, 1, 1, 0, 16'h0010, 16'h0100, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 16'h0010, 16'h0100, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0010, 16'h0100, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0020, 16'h0100, 0, 0, 0, 1, 0, 16'h0100, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0020, 16'h0100, 0, 0, 1, 0, 0, 16'h0020, 0, 1, 32'hCAFE0100));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0020, 16'h0100, 0, 0, 0, 0, 0, 16'h0020, 1, 0, 32'h0BAD0020));
        tbl.push_back(mk(0, 0, 1, 1, 16'h0000, 16'h0200, 32'h12345678, 4'hF, 0, 1, 1, 16'h0200, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0200, 32'h12345678, 4'hF, 0, 0, 0, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 16'h0200, 0, 0, 0, 1, 0, 16'h0200, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 32'h12345678));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 16'h0010, 0, 0, 0));
        foreach (tbl[n]) begin
            drive(tbl[n].rst, tbl[n].ir, tbl[n].mr, tbl[n].mw, tbl[n].ia, tbl[n].ma, tbl[n].wd, tbl[n].wm);
            chk($sformatf("v%0d if_gnt", n), 32'(ig), 32'(tbl[n].eig));
            chk($sformatf("v%0d mem_gnt", n), 32'(mg), 32'(tbl[n].emg));
            chk($sformatf("v%0d ram_we", n), 32'(rwe), 32'(tbl[n].ewe));
            chk($sformatf("v%0d ram_addr", n), 32'(ra), 32'(tbl[n].ea));
            chk($sformatf("v%0d ram_wmask", n), 32'(rwm), tbl[n].ewe ? 32'(tbl[n].wm) : 32'd0);
            chk($sformatf("v%0d if_rvalid", n), 32'(irv), 32'(tbl[n].eirv));
            chk($sformatf("v%0d mem_rvalid", n), 32'(mrv), 32'(tbl[n].emrv));
            if (tbl[n].ewe) chk($sformatf("v%0d ram_wdata", n), rwd, tbl[n].wd);
            if (tbl[n].eirv) chk($sformatf("v%0d if_rdata", n), ird, tbl[n].ed);
            if (tbl[n].emrv) chk($sformatf("v%0d mem_rdata", n), mrd, tbl[n].ed);
            tick();
        end
        // Continuous contention: fetch forced through on the fifth cycle, starve count was cleared by reset.
        for (int k = 1; k <= 9; k++) begin
            drive(0, 1, 1, 0, 16'h0020, 16'h0100, 0, 0);
            chk($sformatf("starve c%0d if_gnt", k), 32'(ig), 32'(k == 5));
            chk($sformatf("starve c%0d mem_gnt", k), 32'(mg), 32'(k != 5));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // A cycle without if_req clears the starve count.
        for (int k = 1; k <= 9; k++) begin
            drive(0, k != 4, 1, 0, 16'h0020, 16'h0100, 0, 0);
            chk($sformatf("clear c%0d if_gnt", k), 32'(ig), 32'(k == 9));
            chk($sformatf("clear c%0d mem_gnt", k), 32'(mg), 32'(k != 9));
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        // Random phase: requesters hold their request until granted.
        denied = 0; owner = 0; pdata = 0;
        ir = 0; mr = 0; mw = 0; ia = 0; ma = 0; wd = 0; wm = 0;
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom % 40) == 0;
            #1;
            eig = !rst && ir && (!mr || (MS > 0 && denied == MS));
            emg = !rst && mr && !eig;
            chk("rnd if_gnt", 32'(ig), 32'(eig));
            chk("rnd mem_gnt", 32'(mg), 32'(emg));
            chk("rnd ram_we", 32'(rwe), 32'(emg && mw));
            chk("rnd ram_addr", 32'(ra), emg ? 32'(ma) : 32'(ia));
            chk("rnd ram_wmask", 32'(rwm), (emg && mw) ? 32'(wm) : 32'd0);
            chk("rnd if_rvalid", 32'(irv), 32'(owner == 1 && !rst));
            chk("rnd mem_rvalid", 32'(mrv), 32'(owner == 2 && !rst));
            if (owner == 1 && !rst) chk("rnd if_rdata", ird, pdata);
            if (owner == 2 && !rst) chk("rnd mem_rdata", mrd, pdata);
            if (emg && mw) chk("rnd ram_wdata", rwd, wd);
            pdata = tb_mem[eig ? ia[9:2] : ma[9:2]];
            owner = rst ? 0 : eig ? 1 : (emg && !mw) ? 2 : 0;
            denied = (rst || !ir || eig) ? 0 : (denied < MS ? denied + 1 : MS);
            tick();
            if (eig || !ir) begin
                ir = ($urandom % 3) != 0;
                ia = 16'($urandom_range(0, 255) << 2);
            end
            if (emg || !mr) begin
                mr = ($urandom % 2) != 0;
                mw = ($urandom % 3) == 0;
                ma = 16'($urandom_range(0, 255) << 2);
                wd = $urandom;
                wm = 4'($urandom);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
